// File: rtl/tcdm_stream_reader_pkg.sv
// Shared types and constants for the TCDM stream reader.
package tcdm_stream_reader_pkg;

  localparam int         TCDM_DATA_W = 32;
  localparam logic [3:0] TCDM_BE_ALL = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/tcdm_stream_reader_fifo.sv
// Response FIFO: DEPTH x DW words, synchronous active-low reset plus soft clear.
// Push and pop in the same cycle are legal at any occupancy; a push into an
// empty FIFO is only visible on data_o the following cycle.
module tcdm_stream_reader_fifo
  import tcdm_stream_reader_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = TCDM_DATA_W,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  output logic [DW-1:0] data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_pop;

  assign do_pop = pop_i & ~empty_o;

  // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_q + CW'(push_i) - CW'(do_pop);
    end
  end

  // Storage; stale contents are harmless since count gates visibility.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;

endmodule

// File: rtl/tcdm_stream_reader.sv
// TCDM stream reader: fetches length_i words at base_addr_i + k*stride_i over a
// TCDM master port and emits them in order as a 32-bit stream.
// Outstanding requests plus buffered words never exceed FIFO_DEPTH, so every
// response has a FIFO slot waiting for it.
// Optional: define TCDM_STREAM_READER_PERF_EN to count req&!gnt stall cycles on
// stall_cnt_o; otherwise stall_cnt_o is tied to zero.
module tcdm_stream_reader
  import tcdm_stream_reader_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   start_i,
  input  logic [31:0]            base_addr_i,
  input  logic [31:0]            stride_i,
  input  logic [LEN_WIDTH-1:0]   length_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [31:0]            stall_cnt_o,
  // TCDM master
  output logic                   tcdm_req,
  input  logic                   tcdm_gnt,
  output logic [31:0]            tcdm_add,
  output logic                   tcdm_wen,
  output logic [3:0]             tcdm_be,
  output logic [TCDM_DATA_W-1:0] tcdm_data,
  input  logic [TCDM_DATA_W-1:0] tcdm_r_data,
  input  logic                   tcdm_r_valid,
  // stream source
  output logic                   stream_valid,
  input  logic                   stream_ready,
  output logic [TCDM_DATA_W-1:0] stream_data,
  output logic [3:0]             stream_strb
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = CW + 1;

  state_t               state_q, state_d;
  logic [31:0]          addr_q, stride_q;
  logic [LEN_WIDTH-1:0] len_q, issued_q, popped_q;
  logic [CW-1:0]        inflight_q, fifo_cnt;
  logic                 fifo_full, fifo_empty;
  logic                 start_acc, gnt_fire, push, pop, last_gnt, last_pop;

  assign start_acc = (state_q == IDLE) & start_i;
  assign gnt_fire  = tcdm_req & tcdm_gnt;
  // A response with nothing in flight belongs to a transfer that was cleared.
  assign push      = tcdm_r_valid & (inflight_q != '0);
  assign pop       = stream_valid & stream_ready;
  assign last_gnt  = gnt_fire & (issued_q == len_q - LEN_WIDTH'(1));
  assign last_pop  = pop & (popped_q == len_q - LEN_WIDTH'(1));

  assign tcdm_req  = (state_q == ISSUE) &
                     (({1'b0, inflight_q} + {1'b0, fifo_cnt}) < SW'(FIFO_DEPTH));
  assign tcdm_add  = addr_q;
  assign tcdm_wen  = 1'b1;
  assign tcdm_be   = TCDM_BE_ALL;
  assign tcdm_data = '0;

  assign stream_valid = ~fifo_empty;
  assign stream_strb  = TCDM_BE_ALL;

  assign busy_o = (state_q == ISSUE) | (state_q == DRAIN);
  assign done_o = (state_q == DONE);

  // Next-state: issue all requests, drain until the last word leaves, pulse done.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = (length_i == '0) ? DONE : ISSUE;
      ISSUE:   if (last_gnt) state_d = DRAIN;
      DRAIN:   if (last_pop) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM, address generator, issue/pop counters and in-flight tracking.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      stride_q   <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      popped_q   <= '0;
      inflight_q <= '0;
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        addr_q   <= base_addr_i;
        stride_q <= stride_i;
        len_q    <= length_i;
        issued_q <= '0;
        popped_q <= '0;
      end else begin
        if (gnt_fire) begin
          addr_q   <= addr_q + stride_q;
          issued_q <= issued_q + LEN_WIDTH'(1);
        end
        if (pop) popped_q <= popped_q + LEN_WIDTH'(1);
      end
      if (gnt_fire && !push)      inflight_q <= inflight_q + CW'(1);
      else if (!gnt_fire && push) inflight_q <= inflight_q - CW'(1);
    end
  end

  tcdm_stream_reader_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (TCDM_DATA_W),
    .CW    (CW)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .push_i  (push),
    .data_i  (tcdm_r_data),
    .pop_i   (pop),
    .data_o  (stream_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  // The credit limit must make an overflowing push impossible.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni || clear_i)
    !(push && fifo_full && !pop));

`ifdef TCDM_STREAM_READER_PERF_EN
  logic [31:0] stall_cnt_q;

  // Saturating count of cycles where a request waits for its grant.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i || start_acc) stall_cnt_q <= '0;
    else if (tcdm_req && !tcdm_gnt && (stall_cnt_q != '1))
      stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_tcdm_stream_reader.sv
// Bench for tcdm_stream_reader: dummy TCDM memory with randomized grant stalls
// and randomized stream backpressure; expected words/addresses come from
// base + k*stride applied to a mirrored memory array.
module tb_tcdm_stream_reader;

  localparam int FIFO_DEPTH = 4;
  localparam int LEN_WIDTH  = 16;
  localparam int MEM_WORDS  = 1024;

  logic                 clk = 1'b0;
  logic                 rst_ni = 1'b0, clear_i = 1'b0, start_i = 1'b0;
  logic [31:0]          base_addr_i = '0, stride_i = '0;
  logic [LEN_WIDTH-1:0] length_i = '0;
  logic                 busy_o, done_o;
  logic [31:0]          stall_cnt_o;
  logic                 tcdm_req, tcdm_wen;
  logic                 tcdm_gnt = 1'b0, tcdm_r_valid = 1'b0;
  logic [31:0]          tcdm_add, tcdm_data, tcdm_r_data = '0;
  logic [3:0]           tcdm_be, stream_strb;
  logic                 stream_valid, stream_ready = 1'b0;
  logic [31:0]          stream_data;

  always #5 clk = ~clk;

  tcdm_stream_reader #(.FIFO_DEPTH(FIFO_DEPTH), .LEN_WIDTH(LEN_WIDTH)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
    .base_addr_i(base_addr_i), .stride_i(stride_i), .length_i(length_i),
    .busy_o(busy_o), .done_o(done_o), .stall_cnt_o(stall_cnt_o),
    .tcdm_req(tcdm_req), .tcdm_gnt(tcdm_gnt), .tcdm_add(tcdm_add),
    .tcdm_wen(tcdm_wen), .tcdm_be(tcdm_be), .tcdm_data(tcdm_data),
    .tcdm_r_data(tcdm_r_data), .tcdm_r_valid(tcdm_r_valid),
    .stream_valid(stream_valid), .stream_ready(stream_ready),
    .stream_data(stream_data), .stream_strb(stream_strb)
  );

  int errors = 0, checks = 0;

  logic [31:0] mem [MEM_WORDS];
  int  stall_pct = 0, ready_pct = 100;
  bit  ready_hold_low = 1'b0;

  // monitor state, written only by the negedge process
  int          cyc = 0, stall_total = 0, done_total = 0, req_total = 0;
  int          valid_total = 0, addr_err = 0, last_done_cyc = 0;
  logic [31:0] got_q[$];
  logic [31:0] add_q[$];
  logic        pend_v = 1'b0, prev_stall = 1'b0;
  logic [31:0] pend_a = '0, prev_add = '0;

  // Dummy memory (latency 1), handshake driver and event recorder.
  always @(negedge clk) begin
    cyc++;
    tcdm_r_valid = pend_v;
    tcdm_r_data  = pend_v ? mem[pend_a[11:2]] : $urandom;
    tcdm_gnt     = tcdm_req && ($urandom_range(99) >= stall_pct);
    stream_ready = !ready_hold_low && ($urandom_range(99) < ready_pct);
    if (tcdm_req && prev_stall && tcdm_add !== prev_add) addr_err++;
    prev_stall = tcdm_req && !tcdm_gnt;
    prev_add   = tcdm_add;
    if (tcdm_req) req_total++;
    if (tcdm_req && !tcdm_gnt) stall_total++;
    if (tcdm_req && tcdm_gnt) add_q.push_back(tcdm_add);
    pend_v = tcdm_req && tcdm_gnt;
    pend_a = tcdm_add;
    if (stream_valid) valid_total++;
    if (stream_valid && stream_ready) got_q.push_back(stream_data);
    if (done_o) begin done_total++; last_done_cyc = cyc; end
  end

  function automatic logic [31:0] exp_addr(input logic [31:0] base, input logic [31:0] stride,
                                           input int k);
    return base + stride * 32'(k);
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] base, input logic [31:0] stride,
                                           input int k);
    logic [31:0] a;
    a = exp_addr(base, stride, k);
    return mem[a[11:2]];
  endfunction

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic run_xfer(input logic [31:0] base, input logic [31:0] stride, input int len,
                          output bit timed_out);
    int db, n;
    db = done_total; n = 0;
    base_addr_i = base; stride_i = stride; length_i = LEN_WIDTH'(len); start_i = 1'b1;
    tick();
    start_i = 1'b0;
    while (done_total == db && n < 4000) begin tick(); n++; end
    timed_out = (done_total == db);
    tick(); tick();
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) tick();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done_o); end
    checks++; if (tcdm_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", tcdm_req); end
    checks++; if (stream_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", stream_valid); end
    checks++; if (stall_cnt_o !== 32'h0) begin errors++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt_o); end
    checks++; if ({tcdm_wen, tcdm_be, tcdm_data, stream_strb} !== {1'b1, 4'hF, 32'h0, 4'hF}) begin
      errors++; $display("FAIL const_outs got wen=%b be=%h data=%h strb=%h exp 1/F/0/F",
                         tcdm_wen, tcdm_be, tcdm_data, stream_strb);
    end
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int gb, ab, db, rb; bit to;
    stall_pct = 0; ready_pct = 100;
    gb = got_q.size(); ab = add_q.size(); db = done_total; rb = req_total;
    run_xfer(32'h0, 32'd4, 8, to);
    checks++; if (to) begin errors++; $display("FAIL basic_timeout got=no done exp=done"); end
    checks++; if (got_q.size() - gb != 8) begin errors++; $display("FAIL basic_count got=%0d exp=8", got_q.size() - gb); end
    for (int k = 0; k < 8 && gb + k < got_q.size(); k++) begin
      checks++; if (got_q[gb+k] !== exp_word(0, 4, k)) begin errors++;
        $display("FAIL basic_data[%0d] got=%h exp=%h", k, got_q[gb+k], exp_word(0, 4, k)); end
      checks++; if (add_q[ab+k] !== exp_addr(0, 4, k)) begin errors++;
        $display("FAIL basic_addr[%0d] got=%h exp=%h", k, add_q[ab+k], exp_addr(0, 4, k)); end
    end
    checks++; if (req_total - rb != 8) begin errors++; $display("FAIL basic_req_cycles got=%0d exp=8", req_total - rb); end
    checks++; if (done_total - db != 1) begin errors++; $display("FAIL basic_done_pulses got=%0d exp=1", done_total - db); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL basic_busy_after got=%b exp=0", busy_o); end
  endtask

  task automatic test_stall();
    int gb, ab, sb, ae; bit to;
    stall_pct = 50; ready_pct = 100;
    gb = got_q.size(); ab = add_q.size(); sb = stall_total; ae = addr_err;
    run_xfer(32'h0, 32'd8, 16, to);
    checks++; if (to) begin errors++; $display("FAIL stall_timeout got=no done exp=done"); end
    checks++; if (got_q.size() - gb != 16) begin errors++; $display("FAIL stall_count got=%0d exp=16", got_q.size() - gb); end
    for (int k = 0; k < 16 && gb + k < got_q.size(); k++) begin
      checks++; if (got_q[gb+k] !== exp_word(0, 8, k)) begin errors++;
        $display("FAIL stall_data[%0d] got=%h exp=%h", k, got_q[gb+k], exp_word(0, 8, k)); end
      checks++; if (add_q[ab+k] !== exp_addr(0, 8, k)) begin errors++;
        $display("FAIL stall_addr[%0d] got=%h exp=%h", k, add_q[ab+k], exp_addr(0, 8, k)); end
    end
    checks++; if (addr_err != ae) begin errors++; $display("FAIL stall_addr_stable got=%0d changes exp=0", addr_err - ae); end
`ifdef TCDM_STREAM_READER_PERF_EN
    checks++; if (stall_cnt_o !== 32'(stall_total - sb)) begin errors++;
      $display("FAIL stall_cnt got=%0d exp=%0d", stall_cnt_o, stall_total - sb); end
`else
    checks++; if (stall_cnt_o !== 32'h0) begin errors++; $display("FAIL stall_cnt_off got=%0d exp=0", stall_cnt_o); end
`endif
    stall_pct = 0;
  endtask

  task automatic test_backpressure();
    int gb, ab, db, n;
    stall_pct = 0; ready_pct = 100; ready_hold_low = 1'b1;
    gb = got_q.size(); ab = add_q.size(); db = done_total;
    base_addr_i = 32'h100; stride_i = 32'd4; length_i = LEN_WIDTH'(12); start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (20) tick();
    checks++; if (add_q.size() - ab != FIFO_DEPTH) begin errors++;
      $display("FAIL bp_grants_before_pop got=%0d exp=%0d", add_q.size() - ab, FIFO_DEPTH); end
    checks++; if (got_q.size() != gb) begin errors++; $display("FAIL bp_no_pop got=%0d exp=0", got_q.size() - gb); end
    ready_hold_low = 1'b0; ready_pct = 60;
    n = 0;
    while (done_total == db && n < 2000) begin tick(); n++; end
    tick();
    checks++; if (done_total == db) begin errors++; $display("FAIL bp_timeout got=no done exp=done"); end
    checks++; if (got_q.size() - gb != 12) begin errors++; $display("FAIL bp_count got=%0d exp=12", got_q.size() - gb); end
    for (int k = 0; k < 12 && gb + k < got_q.size(); k++) begin
      checks++; if (got_q[gb+k] !== exp_word(32'h100, 4, k)) begin errors++;
        $display("FAIL bp_data[%0d] got=%h exp=%h", k, got_q[gb+k], exp_word(32'h100, 4, k)); end
    end
    ready_pct = 100;
  endtask

  task automatic test_zero_len();
    int db, rb, vb, c0; bit to;
    db = done_total; rb = req_total; vb = valid_total; c0 = cyc;
    run_xfer(32'h40, 32'd4, 0, to);
    checks++; if (to) begin errors++; $display("FAIL zero_timeout got=no done exp=done"); end
    checks++; if (done_total - db != 1) begin errors++; $display("FAIL zero_done_pulses got=%0d exp=1", done_total - db); end
    checks++; if (last_done_cyc - c0 != 2) begin errors++; $display("FAIL zero_done_latency got=%0d exp=2", last_done_cyc - c0); end
    checks++; if (req_total != rb) begin errors++; $display("FAIL zero_req got=%0d exp=0", req_total - rb); end
    checks++; if (valid_total != vb) begin errors++; $display("FAIL zero_valid got=%0d exp=0", valid_total - vb); end
  endtask

  task automatic test_neg_stride();
    logic [31:0] bases [2] = '{32'h3FC, 32'h10};
    int          lens  [2] = '{1, 4};
    int gb, ab, db; bit to;
    for (int t = 0; t < 2; t++) begin
      gb = got_q.size(); ab = add_q.size(); db = done_total;
      run_xfer(bases[t], -32'sd4, lens[t], to);
      checks++; if (to || done_total - db != 1) begin errors++;
        $display("FAIL neg_done[%0d] got=%0d pulses exp=1", t, done_total - db); end
      checks++; if (add_q.size() - ab != lens[t]) begin errors++;
        $display("FAIL neg_reqs[%0d] got=%0d exp=%0d", t, add_q.size() - ab, lens[t]); end
      for (int k = 0; k < lens[t] && gb + k < got_q.size() && ab + k < add_q.size(); k++) begin
        checks++; if (add_q[ab+k] !== exp_addr(bases[t], -32'sd4, k)) begin errors++;
          $display("FAIL neg_addr[%0d][%0d] got=%h exp=%h", t, k, add_q[ab+k], exp_addr(bases[t], -32'sd4, k)); end
        checks++; if (got_q[gb+k] !== exp_word(bases[t], -32'sd4, k)) begin errors++;
          $display("FAIL neg_data[%0d][%0d] got=%h exp=%h", t, k, got_q[gb+k], exp_word(bases[t], -32'sd4, k)); end
      end
    end
  endtask

  task automatic test_clear();
    int gb, vb, n, g2; bit to;
    stall_pct = 0; ready_pct = 100;
    gb = got_q.size();
    base_addr_i = 32'h0; stride_i = 32'd4; length_i = LEN_WIDTH'(16); start_i = 1'b1;
    tick();
    start_i = 1'b0;
    n = 0;
    while (got_q.size() - gb < 5 && n < 200) begin tick(); n++; end
    checks++; if (got_q.size() - gb < 5) begin errors++; $display("FAIL clr_progress got=%0d exp>=5", got_q.size() - gb); end
    for (int k = 0; k < 5 && gb + k < got_q.size(); k++) begin
      checks++; if (got_q[gb+k] !== exp_word(0, 4, k)) begin errors++;
        $display("FAIL clr_pre_data[%0d] got=%h exp=%h", k, got_q[gb+k], exp_word(0, 4, k)); end
    end
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    checks++; if ({busy_o, tcdm_req, stream_valid} !== 3'b000) begin errors++;
      $display("FAIL clr_state got busy/req/valid=%b%b%b exp=000", busy_o, tcdm_req, stream_valid); end
    vb = valid_total;
    repeat (4) tick();
    checks++; if (valid_total != vb) begin errors++; $display("FAIL clr_late_rvalid got=%0d valid cycles exp=0", valid_total - vb); end
    g2 = got_q.size();
    run_xfer(32'h40, 32'd4, 4, to);
    checks++; if (to || got_q.size() - g2 != 4) begin errors++; $display("FAIL clr_restart_count got=%0d exp=4", got_q.size() - g2); end
    for (int k = 0; k < 4 && g2 + k < got_q.size(); k++) begin
      checks++; if (got_q[g2+k] !== exp_word(32'h40, 4, k)) begin errors++;
        $display("FAIL clr_restart_data[%0d] got=%h exp=%h", k, got_q[g2+k], exp_word(32'h40, 4, k)); end
    end
  endtask

  task automatic test_random();
    logic [31:0] base, stride;
    int len, gb, ab, db, sb; bit to;
    for (int it = 0; it < 8; it++) begin
      base = 32'($urandom_range(0, MEM_WORDS - 1)) << 2;
      stride = (32'($urandom_range(0, 32)) - 32'd16) << 2;
      len = $urandom_range(1, 24);
      stall_pct = $urandom_range(0, 70); ready_pct = $urandom_range(30, 100);
      gb = got_q.size(); ab = add_q.size(); db = done_total; sb = stall_total;
      run_xfer(base, stride, len, to);
      checks++; if (to || done_total - db != 1) begin errors++;
        $display("FAIL rnd_done[%0d] got=%0d pulses exp=1", it, done_total - db); end
      checks++; if (got_q.size() - gb != len) begin errors++;
        $display("FAIL rnd_count[%0d] got=%0d exp=%0d", it, got_q.size() - gb, len); end
      for (int k = 0; k < len && gb + k < got_q.size() && ab + k < add_q.size(); k++) begin
        checks++; if (got_q[gb+k] !== exp_word(base, stride, k) || add_q[ab+k] !== exp_addr(base, stride, k)) begin
          errors++; $display("FAIL rnd[%0d][%0d] got data=%h addr=%h exp data=%h addr=%h", it, k,
                             got_q[gb+k], add_q[ab+k], exp_word(base, stride, k), exp_addr(base, stride, k)); end
      end
`ifdef TCDM_STREAM_READER_PERF_EN
      checks++; if (stall_cnt_o !== 32'(stall_total - sb)) begin errors++;
        $display("FAIL rnd_stall_cnt[%0d] got=%0d exp=%0d", it, stall_cnt_o, stall_total - sb); end
`endif
    end
    stall_pct = 0; ready_pct = 100;
  endtask

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
    test_reset();
    test_basic();
    test_stall();
    test_backpressure();
    test_zero_len();
    test_neg_stride();
    test_clear();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
